div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division, sampled on the rising edge of clock.
REQ-005 dividend  input  22  unsigned dividend (product-width operand of the mantissa multiplier).
REQ-006 divisor  input  11  unsigned divisor.
REQ-007 ready  output  1  high when the block can accept start (state IDLE).
REQ-008 done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid.
REQ-009 quotient  output  22  unsigned quotient.
REQ-010 remainder  output  11  unsigned remainder, always < divisor when divisor != 0.
REQ-011 div_by_zero  output  1  divisor was zero for the completed operation.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at an edge: capture dividend and divisor; clear the 12-bit partial remainder and the 5-bit step counter; go to RUN.
REQ-014 RUN SHALL run restoring radix-2 division, one quotient bit per cycle, MSB first: shift the next dividend bit into the partial remainder; if partial >= divisor, subtract and set the quotient bit to 1, else set it to 0.
REQ-015 RUN SHALL last exactly 22 edges; the 22nd RUN edge SHALL register the quotient and remainder and go to DONE.
REQ-016 Latency: start accepted at edge N -> done high between edges N+22 and N+23.
REQ-017 DONE SHALL hold done=1 for exactly one cycle, then go to IDLE.
REQ-018 ready SHALL be 1 only in IDLE; start in RUN or DONE SHALL be ignored with no effect.
REQ-019 quotient, remainder and div_by_zero SHALL hold their last completed values until the next completion or reset.
REQ-020 Input changes after the start edge SHALL NOT affect the operation in progress.
REQ-021 Divisor 0 (either configuration): quotient = 22'h3FFFFF, remainder = dividend[10:0].
REQ-022 Dividend 0 with divisor != 0: quotient = 0, remainder = 0, full 22-step latency.

Reset
REQ-023 While reset=1 at an edge: state = IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared.
REQ-024 Reset SHALL take priority over start at the same edge.
REQ-025 Reset in RUN or DONE SHALL abort the operation with no done pulse; outputs take the reset values.

Configuration
REQ-026 Macro DIV_ZERO_CHECK_EN SHALL control divide-by-zero detection.
REQ-027 With DIV_ZERO_CHECK_EN defined: IDLE with start and divisor==0 SHALL go directly to DONE with the REQ-021 results and div_by_zero=1, so done is high between edges N+1 and N+2.
REQ-028 Without DIV_ZERO_CHECK_EN: divisor 0 SHALL take the normal 22-step path, giving the REQ-021 results by the algorithm; div_by_zero SHALL be tied to 0.

Verification
REQ-029 Directed: 100/7 -> quotient 14, remainder 2, done exactly 22 cycles after the start edge; 22'h3FFFFF/1 -> quotient 22'h3FFFFF, remainder 0.
REQ-030 Multiplier inverse sweep: for every a, b in 0..1023 with b != 0, dividend = a*b, divisor = b -> quotient = a, remainder = 0 (e.g. 1046529/1023 -> 1023 r 0).
REQ-031 Divisor 0, dividend 22'h000ABC:
- with the macro: done 1 cycle after start, quotient 22'h3FFFFF, remainder 11'h2BC, div_by_zero 1;
- without the macro: done at 22 cycles, same quotient and remainder, div_by_zero 0.
REQ-032 start pulsed again in RUN at cycle 5 with different operands -> ignored; the original result is returned at 22 cycles; ready stays 0 until IDLE.
REQ-033 Reset asserted in RUN at cycle 10 -> no done pulse, outputs 0, ready=1 next cycle; a new start then completes normally.
REQ-034 Start held high continuously -> back-to-back operations, one every 24 cycles (IDLE, 22 RUN, DONE); every result is correct.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: sequential restoring radix-2 unsigned divider, 22-bit dividend by
// 11-bit divisor, one quotient bit per clock, MSB first.
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   : a zero divisor is detected at start and skips straight to the
//               final step, so done arrives one cycle after the start edge and
//               div_by_zero is raised.
//   undefined : a zero divisor runs the normal 22 steps; the algorithm itself
//               yields quotient = all ones, remainder = dividend[10:0];
//               div_by_zero is tied low.
//
// Handshake: ready is high only in IDLE. A start sampled high while ready is
// high launches one operation (operands captured at that edge). start while
// ready is low is ignored. done is a single-cycle pulse; quotient, remainder
// and div_by_zero are valid during that pulse and hold until the next
// completion or reset.
//
// fsm_state is a debug view of the controller state (0=IDLE, 1=RUN, 2=DONE).
module div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [21:0] dividend,
  input  logic [10:0] divisor,
  output logic        ready,
  output logic        done,
  output logic [21:0] quotient,
  output logic [10:0] remainder,
  output logic        div_by_zero,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the final RUN step (22 steps: 0..21).
  localparam logic [4:0] LAST_STEP = 5'd21;

  state_t      state;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after 22 steps this register holds the full quotient.
  logic [21:0] work;
  logic [10:0] dvs_r;
  logic [11:0] partial;
  logic [4:0]  step;

`ifdef DIV_ZERO_CHECK_EN
  logic        zero_r;
  logic        dbz_r;
`endif

  logic [11:0] shifted;
  logic [11:0] diff;
  logic        fits;
  logic [11:0] next_partial;
  logic [21:0] next_work;

  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor when it fits. partial[11] set means the true shifted value is at
  // least 4096 and therefore always fits.
  always_comb begin
    shifted      = {partial[10:0], work[21]};
    diff         = shifted - {1'b0, dvs_r};
    fits         = partial[11] | (shifted >= {1'b0, dvs_r});
    next_partial = fits ? diff : shifted;
    next_work    = {work[20:0], fits};
  end

  // Controller and datapath registers; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      work      <= '0;
      dvs_r     <= '0;
      partial   <= '0;
      step      <= '0;
`ifdef DIV_ZERO_CHECK_EN
      zero_r    <= 1'b0;
      dbz_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work    <= dividend;
            dvs_r   <= divisor;
            partial <= '0;
            step    <= '0;
            ready   <= 1'b0;
            state   <= RUN;
`ifdef DIV_ZERO_CHECK_EN
            // A zero divisor jumps to the final step so the next edge
            // completes with the fixed divide-by-zero results.
            zero_r  <= (divisor == 11'd0);
            if (divisor == 11'd0) begin
              step <= LAST_STEP;
            end
`endif
          end
        end

        RUN: begin
          work    <= next_work;
          partial <= next_partial;
          step    <= step + 5'd1;
          if (step == LAST_STEP) begin
            quotient  <= next_work;
            remainder <= next_partial[10:0];
`ifdef DIV_ZERO_CHECK_EN
            dbz_r     <= zero_r;
            if (zero_r) begin
              // work still holds the untouched dividend on the shortcut path.
              quotient  <= '1;
              remainder <= work[10:0];
            end
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  assign div_by_zero = dbz_r;
`else
  assign div_by_zero = 1'b0;
`endif

  assign fsm_state = state;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq. A behavioural model (plain / and %)
// predicts every result and its latency; one compare process checks ready,
// done, results and output hold on every falling clock edge.
module tb_div_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [21:0] dividend = '0;
  logic [10:0] divisor = '0;
  logic        ready;
  logic        done;
  logic [21:0] quotient;
  logic [10:0] remainder;
  logic        div_by_zero;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  div_seq dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  // cyc = number of rising edges seen so far.
  always @(posedge clock) cyc <= cyc + 1;

  logic rst_at_edge = 1'b0;
  always @(posedge clock) rst_at_edge <= reset;

  // ---------------- model state ----------------
  localparam int W = 34;  // {quotient, remainder, div_by_zero}
  logic [W-1:0] exp_q[$];
  int           edge_q[$];
  int           lat_q[$];
  logic [21:0]  last_q = '0;
  logic [10:0]  last_r = '0;
  logic         last_z = 1'b0;
  int           busy_from = 0;
  int           idle_from = 0;
  int           last_done_cyc = -1;
  int           op_edge = 0;
  logic [W-1:0] e_cur;
  int           ed_cur;
  int           l_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Division by the rules: ordinary unsigned / and %, fixed results for a zero divisor.
  function automatic void model(input logic [21:0] a, input logic [10:0] b,
                                output logic [21:0] q, output logic [10:0] r,
                                output logic z, output int lat);
    if (b == 11'd0) begin
      q = 22'h3FFFFF;
      r = a[10:0];
`ifdef DIV_ZERO_CHECK_EN
      z = 1'b1;
      lat = 1;
`else
      z = 1'b0;
      lat = 22;
`endif
    end else begin
      q = a / {11'd0, b};
      r = 11'(a % {11'd0, b});
      z = 1'b0;
      lat = 22;
    end
  endfunction

  // Records an operation whose start edge is the next rising edge.
  task automatic push(input logic [21:0] a, input logic [10:0] b);
    logic [21:0] q;
    logic [10:0] r;
    logic        z;
    int          lat;
    model(a, b, q, r, z, lat);
    exp_q.push_back({q, r, z});
    edge_q.push_back(cyc + 1);
    lat_q.push_back(lat);
    busy_from = cyc + 1;
    idle_from = cyc + 1 + lat + 1;
    op_edge   = cyc + 1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (rst_at_edge) begin
      check("reset_ready", ready, 1);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_dbz", div_by_zero, 0);
      exp_q.delete();
      edge_q.delete();
      lat_q.delete();
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
      busy_from = 0;
      idle_from = 0;
    end else begin
      check("ready", ready, (cyc >= busy_from && cyc < idle_from) ? 0 : 1);
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: done=1 at cycle %0d expected 0", cyc);
        end else begin
          e_cur  = exp_q.pop_front();
          ed_cur = edge_q.pop_front();
          l_cur  = lat_q.pop_front();
          check("latency", cyc - ed_cur, l_cur);
          check("quotient", quotient, e_cur[33:12]);
          check("remainder", remainder, e_cur[11:1]);
          check("div_by_zero", div_by_zero, e_cur[0]);
          last_q = e_cur[33:12];
          last_r = e_cur[11:1];
          last_z = e_cur[0];
          last_done_cyc = cyc;
        end
      end else begin
        check("hold_quotient", quotient, last_q);
        check("hold_remainder", remainder, last_r);
        check("hold_dbz", div_by_zero, last_z);
        if (exp_q.size() != 0 && cyc >= edge_q[0] + lat_q[0]) begin
          total++;
          bad++;
          $display("FAIL done_timeout: done=0 at cycle %0d expected 1", cyc);
          void'(exp_q.pop_front());
          void'(edge_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One operation with the DUT idle; operands are scrambled after the start edge.
  task automatic do_op(input logic [21:0] a, input logic [10:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push(a, b);
    tick();
    start    = 1'b0;
    dividend = 22'($urandom);
    divisor  = 11'($urandom);
    repeat (24) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [21:0] mq;
  logic [10:0] mr;
  logic        mz;
  int          ml;
  int          sweep_a[8] = '{0, 1, 2, 3, 511, 512, 1000, 1023};
  int          sweep_b[8] = '{1, 2, 3, 7, 255, 256, 1000, 1023};
  logic [21:0] bb_a[5] = '{22'd100, 22'h3FFFFF, 22'd0, 22'd1046529, 22'd54321};
  logic [10:0] bb_b[5] = '{11'd7, 11'd1, 11'd9, 11'd1023, 11'd100};

  initial begin
    // Hand-computed pins on the model itself.
    model(22'd100, 11'd7, mq, mr, mz, ml);
    check("pin_100_7_q", mq, 14);
    check("pin_100_7_r", mr, 2);
    check("pin_100_7_lat", ml, 22);
    model(22'h3FFFFF, 11'd1, mq, mr, mz, ml);
    check("pin_max_1_q", mq, 22'h3FFFFF);
    check("pin_max_1_r", mr, 0);
    model(22'd1046529, 11'd1023, mq, mr, mz, ml);
    check("pin_sq_q", mq, 1023);
    check("pin_sq_r", mr, 0);
    model(22'h000ABC, 11'd0, mq, mr, mz, ml);
    check("pin_dz_q", mq, 22'h3FFFFF);
    check("pin_dz_r", mr, 11'h2BC);
`ifdef DIV_ZERO_CHECK_EN
    check("pin_dz_z", mz, 1);
`else
    check("pin_dz_z", mz, 0);
`endif

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic directed operations.
    do_op(22'd100, 11'd7);
    check("lat_100_7", last_done_cyc - op_edge, 22);
    do_op(22'h3FFFFF, 11'd1);
    do_op(22'd0, 11'd13);
    do_op(22'h3FFFFF, 11'd2047);
    do_op(22'h2AAAAA, 11'h555);
    do_op(22'd2047, 11'd2047);
    do_op(22'd2046, 11'd2047);

    // Multiplier-inverse sweep on a grid of corner values.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        do_op(22'(sweep_a[i] * sweep_b[j]), 11'(sweep_b[j]));
      end
    end
    for (int k = 0; k < 8; k++) begin
      int a;
      int b;
      a = $urandom_range(0, 1023);
      b = $urandom_range(1, 1023);
      do_op(22'(a * b), 11'(b));
    end

    // Zero divisor.
    do_op(22'h000ABC, 11'd0);
`ifdef DIV_ZERO_CHECK_EN
    check("dz_lat", last_done_cyc - op_edge, 1);
`else
    check("dz_lat", last_done_cyc - op_edge, 22);
`endif
    do_op(22'h3FFFFF, 11'd0);
    do_op(22'd0, 11'd0);

    // A second start during RUN is ignored.
    dividend = 22'd100;
    divisor  = 11'd7;
    start    = 1'b1;
    push(22'd100, 11'd7);
    tick();
    start    = 1'b0;
    repeat (4) tick();
    start    = 1'b1;
    dividend = 22'd999;
    divisor  = 11'd3;
    check("ready_in_run", ready, 0);
    tick();
    start    = 1'b0;
    repeat (19) tick();
    check("ignored_start_lat", last_done_cyc - op_edge, 22);

    // Reset during RUN aborts the operation.
    dividend = 22'd12345;
    divisor  = 11'd67;
    start    = 1'b1;
    push(22'd12345, 11'd67);
    tick();
    start    = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("abort_ready", ready, 1);
    check("abort_quotient", quotient, 0);
    repeat (24) tick();
    do_op(22'd12345, 11'd67);

    // Start held high: back-to-back operations every 24 cycles.
    dividend = bb_a[0];
    divisor  = bb_b[0];
    start    = 1'b1;
    push(bb_a[0], bb_b[0]);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) start = 1'b0;
      dividend = 22'($urandom);
      divisor  = 11'($urandom);
      repeat (23) tick();
      if (k < 5) begin
        dividend = bb_a[k];
        divisor  = bb_b[k];
        push(bb_a[k], bb_b[k]);
      end
    end
    check("b2b_last_lat", last_done_cyc - op_edge, 22);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #800000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
